// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for a stalling CPU. It takes one
//               valid/ready request, inserts wait states, then commits the
//               load or store and returns a response.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [IW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic           err_q;
    logic           resp_valid_q;
    logic [31:0]    rdata_q;
    logic           resp_err_q;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           w_req_err;
    logic           w_commit;
    logic           w_cmt_we;
    logic [IW-1:0]  w_cmt_idx;
    logic [31:0]    w_cmt_wdata;
    logic [3:0]     w_cmt_be;
    logic           w_cmt_err;

    // Upper address bits only matter through the range comparison.
    assign w_req_err = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

    // With zero wait states the commit happens on the accept edge itself,
    // so the request fields are taken straight from the port.
    always_comb begin
        w_commit    = (state_q == S_WAIT) && (cnt_q == 4'd1);
        w_cmt_we    = we_q;
        w_cmt_idx   = idx_q;
        w_cmt_wdata = wdata_q;
        w_cmt_be    = be_q;
        w_cmt_err   = err_q;
        if (WAIT_CYCLES == 0) begin
            w_commit    = req_valid && (state_q == S_IDLE);
            w_cmt_we    = req_we;
            w_cmt_idx   = req_addr[IW+1:2];
            w_cmt_wdata = req_wdata;
            w_cmt_be    = req_be;
            w_cmt_err   = w_req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        idx_q   <= req_addr[IW+1:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= w_req_err;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            cnt_q   <= 4'(WAIT_CYCLES);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        rdata_q      <= 32'd0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (w_commit) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= w_cmt_err;
                rdata_q      <= (!w_cmt_err && !w_cmt_we) ? mem_q[w_cmt_idx] : 32'd0;
                if (!w_cmt_err && w_cmt_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_cmt_be[b]) begin
                            mem_q[w_cmt_idx][8*b +: 8] <= w_cmt_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder (vector table, random
//               traffic against a memory model, and multi-cycle sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int WAITC = 2;
    localparam int ZDEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_we, z_resp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(ZDEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: a word array with byte-lane merge on stores.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic er);
        int unsigned w;
        w  = addr / 4;
        er = (addr % 4 != 0) || (w >= DEPTH);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = ref_mem[w];
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    endtask

    // Called #1 after a rising edge; returns with the handshake done.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
        int guard;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd, mrd, held_rd;
        logic        er, mer;
        int          lat;
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        int          r;

        tbl[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'hDE22_BE44, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[6]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[7]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 32'hAABB_CCDD, 4'h0, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
        tbl[11] = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
        tbl[12] = '{1'b1, 32'h0000_0026, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};

        clear_model();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0;
        z_req_wdata = 32'h0; z_req_be = 4'h0; z_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'b0, resp_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, mrd, mer);
            check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
            check($sformatf("vec%0d latency", i), lat, WAITC);
        end

        for (int i = 0; i < 60; i++) begin
            r     = $urandom_range(0, 9);
            addr  = 32'h100 + 4 * $urandom_range(0, 15);
            if (r == 0) addr = addr + $urandom_range(1, 3);
            if (r == 1) addr = 32'h1000 + 4 * $urandom_range(0, 1000);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            txn(we, addr, wdata, be, rd, er, lat);
            model(we, addr, wdata, be, mrd, mer);
            check($sformatf("rand%0d rdata", i), rd, mrd);
            check($sformatf("rand%0d err", i), {31'b0, er}, {31'b0, mer});
        end

        // Response stall with a new request already waiting on the port.
        model(1'b0, 32'h20, 32'h0, 4'h0, held_rd, mer);
        req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check("stall latency", lat, WAITC);
        req_we = 1'b1; req_addr = 32'h28; req_wdata = 32'h0BAD_F00D; req_be = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d resp_valid", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("stall%0d rdata", i), resp_rdata, held_rd);
            check($sformatf("stall%0d err", i), {31'b0, resp_err}, 32'd0);
            check($sformatf("stall%0d req_ready", i), {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post-handshake req_ready", {31'b0, req_ready}, 32'd1);
        check("post-handshake resp_valid", {31'b0, resp_valid}, 32'd0);
        check("post-handshake rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("held req accepted", {31'b0, req_ready}, 32'd0);
        model(1'b1, 32'h28, 32'h0BAD_F00D, 4'hF, mrd, mer);
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check("held req latency", lat, WAITC);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        txn(1'b0, 32'h28, 32'h0, 4'h0, rd, er, lat);
        check("held store readback", rd, 32'h0BAD_F00D);

        // Reset while a store sits in WAIT.
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFEED_FACE; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("store in WAIT", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        check("abort req_ready", {31'b0, req_ready}, 32'd1);
        check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort rdata", resp_rdata, 32'd0);
        check("abort err", {31'b0, resp_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("abort stays idle", {31'b0, resp_valid}, 32'd0);
        txn(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("aborted store dropped", rd, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("reset clears memory", rd, 32'd0);

        // Zero-wait build: one completion every two cycles with resp_ready high.
        z_resp_ready = 1'b1;
        z_req_we = 1'b0; z_req_addr = 32'h0; z_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("w0 b2b%0d resp_valid", k), {31'b0, z_resp_valid},
                  (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        z_req_valid = 1'b0;
        @(posedge clk); #1;
        z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hCAFE_F00D; z_req_be = 4'hF;
        z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("w0 store latency", {31'b0, z_resp_valid}, 32'd1);
        @(posedge clk); #1;
        z_req_we = 1'b0; z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("w0 load rdata", z_resp_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        z_req_addr = 32'h40; z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("w0 range err", {31'b0, z_resp_err}, 32'd1);
        check("w0 range rdata", z_resp_rdata, 32'd0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data port.
- Accepts load/store requests over a valid/ready request channel and returns completion over a valid/ready response channel.
- Inserts a programmable number of wait states, applies byte enables on stores, and flags misaligned or out-of-range accesses.
- Sits between the CPU load/store path and the word-addressed data RAM. It is used when the CPU is built as a multi-cycle/stalling core.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored. Valid word indices are 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states inserted between request accept and response. Legal range 0..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_be  input  4  store byte enables; bit i gates byte i (bits 8i+7:8i)
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  access error on this response

Behaviour:
- Single clock. Reset is synchronous and active-high: a rising edge of clk with rst=1 resets the block.
- Reset:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - All memory words are cleared to 0.
  - rst in any state aborts an in-flight request; a pending store that has not committed is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs on an edge where req_valid=1 and the state is IDLE.
  - On accept, latch we/addr/wdata/be and compute err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH_WORDS).
  - If WAIT_CYCLES=0, go to RESP. Otherwise load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - On the edge where counter==1, go to RESP.
- Edge entering RESP (commit edge):
  - No error, load: resp_rdata = mem[addr[31:2]].
  - No error, store: mem[addr[31:2]] byte i := wdata byte i for each be[i]=1; resp_rdata=0.
  - Error: no memory change; resp_rdata=0, resp_err=1.
  - resp_valid is set to 1.
- RESP:
  - req_ready=0.
  - resp_valid, resp_rdata and resp_err hold stable until an edge with resp_ready=1.
  - On that edge: resp_valid=0, resp_err=0, resp_rdata=0, go to IDLE.
  - No back-to-back bypass: a new request can be accepted no earlier than the cycle after the response handshake.
- Latency: accept in cycle T gives resp_valid=1 from cycle T+1+WAIT_CYCLES, independent of resp_ready.
- Edge cases:
  - req_be=0 on a store gives an OK response with no memory change.
  - req_be and req_wdata are ignored for loads.
  - req_valid while req_ready=0 is ignored; the requester must hold it.
  - Address bits beyond the word index range are checked only through the range test.

Test Plan:
- Reset, then load from addr 0x0000_0010 with WAIT_CYCLES=2, accept in cycle 0 → resp_valid rises in cycle 3, rdata=0x0000_0000, err=0.
- Store addr 0x20, wdata 0xDEAD_BEEF, be=4'b1111, then load 0x20 → rdata 0xDEAD_BEEF. Then store wdata 0x1122_3344 with be=4'b0101 and load again → rdata 0xDE22_BE44.
- Load addr 0x0000_0022 (misaligned), and separately addr 4*DEPTH_WORDS → err=1, rdata=0. A subsequent load of the last word (4*(DEPTH_WORDS-1)) returns err=0.
- Hold resp_ready=0 for 5 cycles after resp_valid rises → rdata/err stable, req_ready=0 throughout; a new req_valid is not accepted until the cycle after resp_ready=1.
- WAIT_CYCLES=0 build: accept in cycle 0 → resp_valid in cycle 1. Back-to-back requests with resp_ready tied high complete one every 2 cycles.
- Assert rst while in WAIT during a store to 0x40 → outputs return to reset values, req_ready=1, and a load of 0x40 returns 0.
